half_subtractor: RTL and testbench
==================================

Name: half_subtractor

Overview:
Registered, lane-parallel half subtractor. Each of WIDTH independent bit lanes computes A minus B, giving a difference bit and a borrow-out bit. Results are captured on a valid strobe and presented one clock later. The block also keeps a saturating count of borrow events for datapath statistics. It is a leaf arithmetic primitive used ahead of ripple/borrow chains.

Parameters:
WIDTH, 1, number of independent 1-bit subtractor lanes (>=1)
CNT_W, 16, width of the borrow-event counter (>=2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  qualifies A/B for capture this cycle
A  input  WIDTH  minuend bits, lane i = A[i]
B  input  WIDTH  subtrahend bits, lane i = B[i]
clr_cnt  input  1  synchronous clear of borr_cnt
out_valid  output  1  high for one cycle when Diff/Borr hold a new result
Diff  output  WIDTH  registered difference bits
Borr  output  WIDTH  registered borrow-out bits
borr_cnt  output  CNT_W  saturating total of borrow bits produced

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Per-lane function: Diff[i] = A[i] XOR B[i]; Borr[i] = (NOT A[i]) AND B[i].
- Truth table per lane (A B -> Diff Borr): 00->0 0, 01->1 1, 10->1 0, 11->0 0.
- Reset (rst_n=0 at a rising edge): Diff=0, Borr=0, out_valid=0, borr_cnt=0. Reset overrides in_valid and clr_cnt.
- Latency is one cycle. If in_valid=1 at edge k, then after edge k Diff/Borr show that result and out_valid=1.
- If in_valid=0 at an edge, out_valid=0 and Diff/Borr hold their previous values.
- Back-to-back in_valid works every cycle with full throughput; there is no backpressure.
- A/B are ignored when in_valid=0, including X values; X must not reach the registers.
- Counter: on each accepted input, borr_cnt += popcount of the new Borr vector (0..WIDTH).
- Counter saturation: the counter saturates at 2^CNT_W-1 and never wraps. A partial add that would overflow clamps to the maximum.
- clr_cnt=1 at an edge: borr_cnt=0. Clear has priority over a simultaneous increment; that cycle's borrows are not counted. Diff/Borr/out_valid are unaffected by clr_cnt.
- Reset mid-stream discards the in-flight result. out_valid is 0 in the cycle after the reset edge.
- No combinational path from inputs to outputs; all outputs come directly from flops.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, A=1, B=1 -> Diff=0, Borr=0, out_valid=0, borr_cnt=0.
- Truth table, WIDTH=1: apply (A,B)=00,01,10,11 on consecutive cycles with in_valid=1 -> one cycle later (Diff,Borr)=00,11,10,00, out_valid high 4 cycles, borr_cnt=1.
- Hold: after A=0, B=1 is accepted, drop in_valid and drive A=1, B=0 -> Diff=1, Borr=1 persist; out_valid=0; borr_cnt unchanged.
- Multi-lane, WIDTH=4: A=4'b0101, B=4'b0011 -> Diff=4'b0110, Borr=4'b0010, borr_cnt +1; then A=0, B=4'b1111 -> Borr=4'b1111, borr_cnt +4.
- Saturation, CNT_W=2: issue A=0, B=1 four times -> borr_cnt reads 1, 2, 3, 3.
- Clear priority: clr_cnt=1 in the same cycle as an accepted A=0, B=1 -> borr_cnt=0, Borr=1, out_valid=1.

Source files
------------

// File: rtl/half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
//
// Registered, lane-parallel half subtractor. Each of WIDTH independent lanes
// computes A[i] - B[i], giving a difference bit and a borrow-out bit. Inputs
// are captured when in_valid is high and the result is presented one clock
// later. A saturating counter accumulates the number of borrow bits produced
// by accepted inputs, for datapath statistics.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   in_valid  in   1      qualifies A/B for capture this cycle
//   A         in   WIDTH  minuend bits, lane i = A[i]
//   B         in   WIDTH  subtrahend bits, lane i = B[i]
//   clr_cnt   in   1      synchronous clear of borr_cnt (wins over increment)
//   out_valid out  1      one-cycle pulse when Diff/Borr hold a new result
//   Diff      out  WIDTH  registered difference bits
//   Borr      out  WIDTH  registered borrow-out bits
//   borr_cnt  out  CNT_W  saturating count of borrow bits produced
//
// All outputs are driven directly by flops.
// -----------------------------------------------------------------------------
module half_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] Diff,
    output logic [WIDTH-1:0] Borr,
    output logic [CNT_W-1:0] borr_cnt
);

    // Popcount of a WIDTH-bit vector needs clog2(WIDTH+1) bits.
    localparam int PC_W  = $clog2(WIDTH + 1);
    // Sum width: one bit wider than the larger operand so the add never
    // wraps before the saturation compare.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_borr;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_diff_next;
    logic [WIDTH-1:0] w_borr_next;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_inc;

    // Gate operands with in_valid so unknown A/B on idle cycles can never
    // reach the datapath or counter logic.
    assign w_a = in_valid ? A : '0;
    assign w_b = in_valid ? B : '0;

    assign w_diff_next = w_a ^ w_b;
    assign w_borr_next = ~w_a & w_b;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PC_W'(w_borr_next[i]);
        end
    end

    // Saturating add: a partial add that would overflow clamps to all-ones.
    always_comb begin
        w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
        w_cnt_inc = '0;
        if (w_sum > SUM_W'(CNT_MAX)) begin
            w_cnt_inc = CNT_MAX;
        end else begin
            w_cnt_inc = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff      <= '0;
            r_borr      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_diff <= w_diff_next;
                r_borr <= w_borr_next;
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign out_valid = r_out_valid;
    assign Diff      = r_diff;
    assign Borr      = r_borr;
    assign borr_cnt  = r_cnt;

endmodule

// File: tb/tb_half_subtractor.sv
module tb_half_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       clr_cnt;
    logic [3:0] A;
    logic [3:0] B;

    logic        ov1;
    logic [0:0]  d1, b1;
    logic [15:0] cnt1;
    logic        ov4;
    logic [3:0]  d4, b4;
    logic [15:0] cnt4;
    logic        ovs;
    logic [3:0]  ds, bs;
    logic [1:0]  cnts;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_diff = 0, m_borr = 0, m_ov = 0;
    int m_cnt1 = 0, m_cnt4 = 0, m_cnts = 0;

    always #5 clk = ~clk;

    half_subtractor #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A[0:0]), .B(B[0:0]),
        .clr_cnt(clr_cnt), .out_valid(ov1), .Diff(d1), .Borr(b1), .borr_cnt(cnt1)
    );

    half_subtractor #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .clr_cnt(clr_cnt), .out_valid(ov4), .Diff(d4), .Borr(b4), .borr_cnt(cnt4)
    );

    half_subtractor #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .clr_cnt(clr_cnt), .out_valid(ovs), .Diff(ds), .Borr(bs), .borr_cnt(cnts)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_add(input int a, input int b, input int maxv);
        return (a + b > maxv) ? maxv : a + b;
    endfunction

    // Drive one cycle, advance the model by the specified rules, compare all DUTs.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic clr, input logic rst);
        int nd, nb, nbits, ai, bi;
        rst_n    = rst;
        in_valid = v;
        clr_cnt  = clr;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_diff = 0; m_borr = 0; m_ov = 0;
            m_cnt1 = 0; m_cnt4 = 0; m_cnts = 0;
        end else begin
            nbits = 0;
            if (v) begin
                nd = 0; nb = 0;
                for (int i = 0; i < 4; i++) begin
                    ai = a[i] ? 1 : 0;
                    bi = b[i] ? 1 : 0;
                    // Lane result from the arithmetic difference ai - bi
                    if (((ai - bi) % 2) != 0) nd += (1 << i);
                    if (ai < bi) begin
                        nb += (1 << i);
                        nbits++;
                    end
                end
                m_diff = nd;
                m_borr = nb;
            end
            m_ov = v ? 1 : 0;
            if (clr) begin
                m_cnt1 = 0; m_cnt4 = 0; m_cnts = 0;
            end else if (v) begin
                m_cnt1 = sat_add(m_cnt1, m_borr & 1, 65535);
                m_cnt4 = sat_add(m_cnt4, nbits, 65535);
                m_cnts = sat_add(m_cnts, nbits, 3);
            end
        end
        chk("ov_w1",   32'(ov1),  32'(m_ov));
        chk("diff_w1", 32'(d1),   32'(m_diff & 1));
        chk("borr_w1", 32'(b1),   32'(m_borr & 1));
        chk("cnt_w1",  32'(cnt1), 32'(m_cnt1));
        chk("ov_w4",   32'(ov4),  32'(m_ov));
        chk("diff_w4", 32'(d4),   32'(m_diff));
        chk("borr_w4", 32'(b4),   32'(m_borr));
        chk("cnt_w4",  32'(cnt4), 32'(m_cnt4));
        chk("ov_sat",  32'(ovs),  32'(m_ov));
        chk("diff_sat",32'(ds),   32'(m_diff));
        chk("borr_sat",32'(bs),   32'(m_borr));
        chk("cnt_sat", 32'(cnts), 32'(m_cnts));
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic       rv, rc, rr;

        // Reset overrides a valid 1-1 input
        step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("rst_ov",  32'(ov1),  32'd0);
        chk("rst_cnt", 32'(cnt4), 32'd0);

        // Truth table on lane 0, back to back
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("tt00", {30'd0, d1, b1}, 32'b00);
        step(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1);
        chk("tt01", {30'd0, d1, b1}, 32'b11);
        step(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
        chk("tt10", {30'd0, d1, b1}, 32'b10);
        step(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1);
        chk("tt11", {30'd0, d1, b1}, 32'b00);
        chk("tt_cnt", 32'(cnt1), 32'd1);

        // Hold: accept 0-1, then idle with different operands
        step(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1);
        step(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1);
        chk("hold_d", 32'(d1), 32'd1);
        chk("hold_b", 32'(b1), 32'd1);
        chk("hold_ov", 32'(ov1), 32'd0);
        step(1'b0, 4'bxxxx, 4'bxxxx, 1'b0, 1'b1);
        chk("hold_cnt", 32'(cnt1), 32'd2);

        // Multi-lane
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        step(1'b1, 4'b0101, 4'b0011, 1'b0, 1'b1);
        chk("ml_diff", 32'(d4), 32'b0110);
        chk("ml_borr", 32'(b4), 32'b0010);
        chk("ml_cnt1", 32'(cnt4), 32'd1);
        step(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
        chk("ml_borr2", 32'(b4), 32'b1111);
        chk("ml_cnt2", 32'(cnt4), 32'd5);

        // Saturation of the 2-bit counter
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        step(1'b1, 4'h0, 4'h1, 1'b0, 1'b1); chk("sat1", 32'(cnts), 32'd1);
        step(1'b1, 4'h0, 4'h1, 1'b0, 1'b1); chk("sat2", 32'(cnts), 32'd2);
        step(1'b1, 4'h0, 4'h1, 1'b0, 1'b1); chk("sat3", 32'(cnts), 32'd3);
        step(1'b1, 4'h0, 4'h1, 1'b0, 1'b1); chk("sat4", 32'(cnts), 32'd3);
        // Partial add overflow clamps
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        step(1'b1, 4'h0, 4'h3, 1'b0, 1'b1); chk("psat1", 32'(cnts), 32'd2);
        step(1'b1, 4'h0, 4'h3, 1'b0, 1'b1); chk("psat2", 32'(cnts), 32'd3);

        // Clear wins over same-cycle increment
        step(1'b1, 4'h0, 4'h1, 1'b1, 1'b1);
        chk("clr_cnt", 32'(cnt1), 32'd0);
        chk("clr_borr", 32'(b1), 32'd1);
        chk("clr_ov", 32'(ov1), 32'd1);

        // Reset mid-stream drops the in-flight result
        step(1'b1, 4'h0, 4'hF, 1'b0, 1'b1);
        step(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
        chk("mid_rst_ov", 32'(ov4), 32'd0);
        chk("mid_rst_b", 32'(b4), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 49) != 0);
            ra = 4'($urandom);
            rb = 4'($urandom);
            if (!rv && $urandom_range(0, 1) == 1) begin
                ra = 4'bxxxx;
                rb = 4'bxxxx;
            end
            step(rv, ra, rb, rc, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
